// File: rtl/img_frame_reader_pkg.sv
// Shared definitions for the frame reader: state encodings, buffer layout defaults and pixel width.
// Optional feature macro used by the reader: IMG_READER_LATCH_GAP_EN.
package img_frame_reader_pkg;

    typedef enum logic [2:0] {
        IMG_RD_ST_IDLE  = 3'd0,
        IMG_RD_ST_READ  = 3'd1,
        IMG_RD_ST_PUSH  = 3'd2,
        IMG_RD_ST_LATCH = 3'd3,
        IMG_RD_ST_DONE  = 3'd4
    } img_rd_state_e;

    localparam logic [31:0] IMG_RD_BUF_BASE_ADDR = 32'h0001_0000;
    localparam int          IMG_RD_BUF_STRIDE    = 1024;
    localparam int          PIXEL_WIDTH          = 24;

    // display_image pulse period (clk cycles) used by the image control logic for the same strip
    localparam int          FRAME_TIME           = 1_000_000;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/img_frame_reader_if.sv
// Wishbone read master plus valid/ready pixel stream bundled for the frame reader.
interface img_frame_reader_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    import img_frame_reader_pkg::*;

    logic [ADDR_WIDTH-1:0]  wbm_address;
    logic [DATA_WIDTH-1:0]  wbm_writedata;
    logic [DATA_WIDTH-1:0]  wbm_readdata;
    logic                   wbm_strobe;
    logic                   wbm_cycle;
    logic                   wbm_write;
    logic                   wbm_ack;
    logic [PIXEL_WIDTH-1:0] pix_data;
    logic                   pix_valid;
    logic                   pix_ready;

    modport master (
        output wbm_address, wbm_writedata, wbm_strobe, wbm_cycle, wbm_write,
        input  wbm_readdata, wbm_ack,
        output pix_data, pix_valid,
        input  pix_ready
    );

    modport slave (
        input  wbm_address, wbm_writedata, wbm_strobe, wbm_cycle, wbm_write,
        output wbm_readdata, wbm_ack,
        input  pix_data, pix_valid,
        output pix_ready
    );

endinterface

// File: rtl/img_frame_reader.sv
// Fetches one frame buffer word by word over Wishbone and streams GRB pixels to the LED serializer.
// Define IMG_READER_LATCH_GAP_EN to insert an idle LATCH_CYCLES gap between the last pixel and done.
module img_frame_reader
    import img_frame_reader_pkg::*;
#(
    parameter int          ADDR_WIDTH       = 32,
    parameter int          DATA_WIDTH       = 32,
    parameter int          PIXELS_PER_FRAME = 256,
    parameter logic [31:0] BUF_BASE_ADDR    = IMG_RD_BUF_BASE_ADDR,
    parameter int          BUF_STRIDE       = IMG_RD_BUF_STRIDE,
    parameter int          LATCH_CYCLES     = 2500
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] display_image_buf_id,
    input  logic                  display_image,
    output logic                  display_image_done,
    output logic                  busy,
    img_frame_reader_if.master    bus
);

    localparam int                IDX_W    = cnt_width(PIXELS_PER_FRAME);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(PIXELS_PER_FRAME - 1);

    img_rd_state_e          state_q, state_d;
    logic [IDX_W-1:0]       pix_idx_q, pix_idx_d;
    logic [DATA_WIDTH-1:0]  buf_id_q, buf_id_d;
    logic [PIXEL_WIDTH-1:0] pix_data_q, pix_data_d;
    logic [ADDR_WIDTH-1:0]  rd_addr;

`ifdef IMG_READER_LATCH_GAP_EN
    localparam int               LAT_W    = cnt_width(LATCH_CYCLES);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATCH_CYCLES - 1);
    logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
`else
    logic unused_latch_cfg;
    assign unused_latch_cfg = (LATCH_CYCLES < 0);
`endif

    // Upper readdata bits carry no pixel information.
    logic unused_rd_hi;
    assign unused_rd_hi = ^bus.wbm_readdata[DATA_WIDTH-1:PIXEL_WIDTH];

    // Address arithmetic is done at ADDR_WIDTH so large ids wrap instead of overflowing.
    assign rd_addr = ADDR_WIDTH'(BUF_BASE_ADDR)
                   + ADDR_WIDTH'(buf_id_q) * ADDR_WIDTH'(BUF_STRIDE)
                   + (ADDR_WIDTH'(pix_idx_q) << 2);

    always_comb begin
        state_d    = state_q;
        pix_idx_d  = pix_idx_q;
        buf_id_d   = buf_id_q;
        pix_data_d = pix_data_q;
`ifdef IMG_READER_LATCH_GAP_EN
        lat_cnt_d  = lat_cnt_q;
`endif
        case (state_q)
            IMG_RD_ST_IDLE: begin
                if (display_image) begin
                    buf_id_d  = display_image_buf_id;
                    pix_idx_d = '0;
                    state_d   = IMG_RD_ST_READ;
                end
            end
            IMG_RD_ST_READ: begin
                if (bus.wbm_ack) begin
                    pix_data_d = bus.wbm_readdata[PIXEL_WIDTH-1:0];
                    state_d    = IMG_RD_ST_PUSH;
                end
            end
            IMG_RD_ST_PUSH: begin
                if (bus.pix_ready) begin
                    if (pix_idx_q == IDX_LAST) begin
`ifdef IMG_READER_LATCH_GAP_EN
                        lat_cnt_d = '0;
                        state_d   = IMG_RD_ST_LATCH;
`else
                        state_d   = IMG_RD_ST_DONE;
`endif
                    end else begin
                        pix_idx_d = pix_idx_q + 1'b1;
                        state_d   = IMG_RD_ST_READ;
                    end
                end
            end
`ifdef IMG_READER_LATCH_GAP_EN
            IMG_RD_ST_LATCH: begin
                if (lat_cnt_q == LAT_LAST) begin
                    state_d = IMG_RD_ST_DONE;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end
`endif
            IMG_RD_ST_DONE: begin
                state_d = IMG_RD_ST_IDLE;
            end
            default: begin
                state_d = IMG_RD_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IMG_RD_ST_IDLE;
            pix_idx_q  <= '0;
            buf_id_q   <= '0;
            pix_data_q <= '0;
`ifdef IMG_READER_LATCH_GAP_EN
            lat_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pix_idx_q  <= pix_idx_d;
            buf_id_q   <= buf_id_d;
            pix_data_q <= pix_data_d;
`ifdef IMG_READER_LATCH_GAP_EN
            lat_cnt_q  <= lat_cnt_d;
`endif
        end
    end

    assign bus.wbm_cycle     = (state_q == IMG_RD_ST_READ);
    assign bus.wbm_strobe    = (state_q == IMG_RD_ST_READ);
    assign bus.wbm_address   = (state_q == IMG_RD_ST_READ) ? rd_addr : '0;
    assign bus.wbm_writedata = '0;
    assign bus.wbm_write     = 1'b0;
    assign bus.pix_valid     = (state_q == IMG_RD_ST_PUSH);
    assign bus.pix_data      = pix_data_q;
    assign display_image_done = (state_q == IMG_RD_ST_DONE);
    assign busy               = (state_q != IMG_RD_ST_IDLE);

endmodule

// File: tb/tb_img_frame_reader.sv
// Randomized bench for img_frame_reader: memory/serializer responder plus frame-level reference model.
module tb_img_frame_reader;

    localparam int          N       = 4;
    localparam logic [31:0] BASE    = 32'h0001_0000;
    localparam int          STRIDE  = 1024;
    localparam int          LAT_CYC = 10;
`ifdef IMG_READER_LATCH_GAP_EN
    localparam int          GAP     = LAT_CYC;
`else
    localparam int          GAP     = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] buf_id;
    logic        display_image;
    logic        done;
    logic        busy;

    img_frame_reader_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    img_frame_reader #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .PIXELS_PER_FRAME(N),
        .BUF_BASE_ADDR(BASE), .BUF_STRIDE(STRIDE), .LATCH_CYCLES(LAT_CYC)
    ) dut (
        .clk(clk), .reset(reset),
        .display_image_buf_id(buf_id), .display_image(display_image),
        .display_image_done(done), .busy(busy),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Memory contents and responder behaviour, set per frame by the stimulus
    logic [7:0]  salt;
    logic [23:0] mix;
    bit          stray_en;
    int          ack_tbl[16];
    int          stall_tbl[16];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {salt, a[23:0] ^ mix};
    endfunction

    function automatic logic [31:0] model_addr(input logic [31:0] id, input int i);
        logic [63:0] full;
        full = 64'(BASE) + 64'(id) * 64'(STRIDE) + 64'(4 * i);
        return full[31:0];
    endfunction

    // Observations gathered by the responder
    logic [31:0] got_addr[$];
    logic [23:0] got_pix[$];
    int req_idx, pix_idx, wait_cnt, stall_cnt;
    int strobe_cycles, valid_cycles, busy_cycles, done_cnt;
    logic [31:0] req_addr;
    logic [23:0] held_pix;

    always @(negedge clk) begin
        if (bus.wbm_cycle && bus.wbm_strobe) begin
            strobe_cycles++;
            if (wait_cnt == 0) req_addr = bus.wbm_address;
            else chk("addr_stable", bus.wbm_address, req_addr);
            if (wait_cnt >= ack_tbl[req_idx % 16]) begin
                bus.wbm_ack      = 1'b1;
                bus.wbm_readdata = mem_word(bus.wbm_address);
                got_addr.push_back(bus.wbm_address);
                req_idx++;
                wait_cnt = 0;
            end else begin
                bus.wbm_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            bus.wbm_ack      = stray_en && ($urandom_range(0, 3) == 0);
            bus.wbm_readdata = $urandom;
            wait_cnt = 0;
        end
        if (bus.pix_valid) begin
            valid_cycles++;
            if (stall_cnt == 0) held_pix = bus.pix_data;
            else chk("pix_stable", bus.pix_data, held_pix);
            if (stall_cnt >= stall_tbl[pix_idx % 16]) begin
                bus.pix_ready = 1'b1;
                got_pix.push_back(bus.pix_data);
                pix_idx++;
                stall_cnt = 0;
            end else begin
                bus.pix_ready = 1'b0;
                stall_cnt++;
            end
        end else begin
            bus.pix_ready = 1'($urandom_range(0, 1));
            stall_cnt = 0;
        end
        if (busy) busy_cycles++;
        if (done) done_cnt++;
    end

    task automatic clear_obs();
        got_addr.delete();
        got_pix.delete();
        req_idx = 0; pix_idx = 0;
        strobe_cycles = 0; valid_cycles = 0; busy_cycles = 0; done_cnt = 0;
    endtask

    task automatic run_frame(input string name, input logic [31:0] id,
                             input bit pulse_busy, input bit pulse_done);
        logic [31:0] exp_addr[$];
        logic [23:0] exp_pix[$];
        int exp_lat, sum_ack, sum_stall, start_cyc, done_cyc;
        bit done_seen;
        logic [31:0] w;
        sum_ack = 0; sum_stall = 0; done_cyc = 0; done_seen = 0;
        for (int i = 0; i < N; i++) begin
            exp_addr.push_back(model_addr(id, i));
            w = mem_word(model_addr(id, i));
            exp_pix.push_back(w[23:0]);
            sum_ack += ack_tbl[i];
            sum_stall += stall_tbl[i];
        end
        exp_lat = 2 + 2 * N + sum_ack + sum_stall + GAP;
        @(negedge clk);
        clear_obs();
        start_cyc = cyc;
        display_image = 1'b1;
        buf_id = id;
        for (int k = 0; k < 4000 && !done_seen; k++) begin
            @(negedge clk);
            display_image = 1'b0;
            buf_id = $urandom;
            if (pulse_busy && k == 3) begin
                display_image = 1'b1;
                buf_id = ~id;
            end
            if (done) begin
                done_seen = 1;
                done_cyc = cyc;
                if (pulse_done) begin
                    display_image = 1'b1;
                    buf_id = ~id;
                end
            end
        end
        @(negedge clk);
        display_image = 1'b0;
        repeat (3) @(negedge clk);
        chk({name, "_done_seen"}, 64'(done_seen), 64'd1);
        chk({name, "_latency"}, 64'(done_cyc - start_cyc + 1), 64'(exp_lat));
        chk({name, "_done_cnt"}, 64'(done_cnt), 64'd1);
        chk({name, "_busy_cycles"}, 64'(busy_cycles), 64'(exp_lat - 1));
        chk({name, "_strobe_cycles"}, 64'(strobe_cycles), 64'(N + sum_ack));
        chk({name, "_valid_cycles"}, 64'(valid_cycles), 64'(N + sum_stall));
        chk({name, "_idle_after"}, 64'(busy), 64'd0);
        chk({name, "_pix_count"}, 64'(got_pix.size()), 64'(N));
        for (int i = 0; i < N; i++) begin
            chk({name, "_addr"}, (i < got_addr.size()) ? 64'(got_addr[i]) : 64'hx, 64'(exp_addr[i]));
            chk({name, "_pix"}, (i < got_pix.size()) ? 64'(got_pix[i]) : 64'hx, 64'(exp_pix[i]));
        end
        $display("frame %s id=%08h pixels=%0d latency=%0d expected_latency=%0d",
                 name, id, got_pix.size(), done_cyc - start_cyc + 1, exp_lat);
    endtask

    task automatic zero_tables();
        for (int i = 0; i < 16; i++) begin
            ack_tbl[i] = 0;
            stall_tbl[i] = 0;
        end
    endtask

    initial begin
        bit found;
        reset = 1'b1; display_image = 1'b0; buf_id = '0;
        bus.wbm_ack = 1'b0; bus.wbm_readdata = '0; bus.pix_ready = 1'b0;
        salt = 8'hAA; mix = '0; stray_en = 0;
        zero_tables();
        clear_obs();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_cycle", 64'(bus.wbm_cycle), 64'd0);
        chk("rst_strobe", 64'(bus.wbm_strobe), 64'd0);
        chk("rst_address", 64'(bus.wbm_address), 64'd0);
        chk("rst_write", 64'({bus.wbm_write, bus.wbm_writedata}), 64'd0);
        chk("rst_valid", 64'(bus.pix_valid), 64'd0);
        chk("rst_pix_data", 64'(bus.pix_data), 64'd0);
        chk("rst_done_busy", 64'({done, busy}), 64'd0);

        // Zero-wait frame from buffer 2
        run_frame("basic", 32'd2, 0, 0);
        for (int i = 0; i < N; i++)
            chk("basic_abs_addr", (i < got_addr.size()) ? 64'(got_addr[i]) : 64'hx,
                64'(32'h0001_0800 + 32'(4 * i)));

        // Slow ack and stalled serializer on pixel 1
        salt = 8'($urandom); mix = 24'($urandom); stray_en = 1;
        ack_tbl[1] = 3; stall_tbl[1] = 5;
        run_frame("stall", 32'd2, 0, 0);
        zero_tables();

        // Start pulses while busy and during done are dropped
        run_frame("ignore", 32'd9, 1, 1);
        run_frame("id0", 32'd0, 0, 0);
        chk("id0_first_addr", (got_addr.size() > 0) ? 64'(got_addr[0]) : 64'hx, 64'h0001_0000);

        // Reset while waiting for ack at index 2
        ack_tbl[2] = 4;
        @(negedge clk);
        clear_obs();
        display_image = 1'b1; buf_id = 32'd5;
        found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            display_image = 1'b0;
            if (bus.wbm_strobe && bus.wbm_address == model_addr(32'd5, 2)) found = 1;
        end
        chk("rst_mid_reached", 64'(found), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_bus", 64'({bus.wbm_cycle, bus.wbm_strobe}), 64'd0);
        chk("rst_mid_valid", 64'(bus.pix_valid), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_mid_no_done", 64'(done_cnt), 64'd0);
        zero_tables();
        run_frame("after_rst", 32'd7, 0, 0);

        // Address wrap for the largest id
        run_frame("wrap", 32'hFFFF_FFFF, 0, 0);
        chk("wrap_first_addr", (got_addr.size() > 0) ? 64'(got_addr[0]) : 64'hx, 64'h0000_FC00);

        // Randomized frames
        for (int f = 0; f < 8; f++) begin
            salt = 8'($urandom); mix = 24'($urandom);
            for (int i = 0; i < 16; i++) begin
                ack_tbl[i]   = $urandom_range(0, 3);
                stall_tbl[i] = $urandom_range(0, 3);
            end
            run_frame("rand", $urandom, f[0], f[1]);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/img_frame_reader.md
Name: img_frame_reader

Overview:
- Display-side consumer of the image control logic.
- On each display_image pulse it fetches the selected frame buffer word by word over a Wishbone master from shared image memory, and streams pixels to the LED serializer over a valid/ready interface.
- Pulses display_image_done after the last pixel is accepted.
- One pixel per 32-bit word: bits [23:0] are GRB; bits above 23 are ignored.

Parameters:
- ADDR_WIDTH, 32, Wishbone address width.
- DATA_WIDTH, 32, Wishbone data width and buf_id width.
- PIXELS_PER_FRAME, 256, pixels per frame; must be >= 1.
- BUF_BASE_ADDR, 32'h0001_0000, byte address of buffer 0.
- BUF_STRIDE, 1024, byte distance between consecutive buffers.
- LATCH_CYCLES, 2500, idle gap after the last pixel; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- display_image_buf_id  in  DATA_WIDTH  buffer to show; sampled on accepted display_image.
- display_image  in  1  start request, single-cycle pulse.
- display_image_done  out  1  one-cycle pulse when the frame is complete.
- busy  out  1  high from the accepted start until the done pulse, inclusive.
- wbm_address  out  ADDR_WIDTH  read address.
- wbm_writedata  out  DATA_WIDTH  tied to 0.
- wbm_readdata  in  DATA_WIDTH  read data.
- wbm_strobe  out  1  Wishbone strobe.
- wbm_cycle  out  1  Wishbone cycle.
- wbm_write  out  1  tied to 0.
- wbm_ack  in  1  Wishbone acknowledge.
- pix_data  out  24  GRB pixel.
- pix_valid  out  1  pixel available.
- pix_ready  in  1  serializer accepts the pixel.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high. All state changes happen on the rising edge of clk.
- Reset values: state IDLE, pixel index 0, latched id 0, pix_data 0; all outputs 0.
- States: IDLE, READ, PUSH, LATCH (optional feature only), DONE.
- IDLE:
  - On display_image=1: latch display_image_buf_id, clear the index, go to READ.
  - display_image is ignored in every other state. The frame is dropped; no queueing.
- READ:
  - wbm_cycle = wbm_strobe = 1, driven combinationally from state.
  - wbm_address = BUF_BASE_ADDR + id*BUF_STRIDE + index*4, truncated to ADDR_WIDTH (wrap-around permitted).
  - Strobe is held until wbm_ack. On the ack edge, capture wbm_readdata[23:0] into pix_data and go to PUSH.
  - An ack arriving outside READ is ignored.
- PUSH:
  - pix_valid=1; pix_data is stable while pix_valid=1 and pix_ready=0.
  - On pix_valid & pix_ready:
    - If index == PIXELS_PER_FRAME-1: go to DONE (or LATCH when the feature is on).
    - Otherwise increment the index and go to READ.
- DONE: display_image_done=1 for exactly one cycle, then IDLE. A display_image pulse during DONE is ignored.
- Minimum frame latency: 2 + 2*PIXELS_PER_FRAME cycles from start to done, with zero-wait ack and ready.
- Index register width: clog2(PIXELS_PER_FRAME), minimum 1 bit. PIXELS_PER_FRAME=1 reads exactly one word.
- busy = (state != IDLE).
- Reset mid-frame: the bus cycle and pix_valid drop on the reset edge, no done pulse is issued, and the next frame restarts at index 0.

Optional Feature:
- Macro: IMG_READER_LATCH_GAP_EN.
- Defined: after the last pixel is accepted, enter LATCH.
  - The counter runs 0..LATCH_CYCLES-1 with pix_valid=0 and the bus idle, then goes to DONE.
  - busy stays high throughout, so the LED strip gets its reset/latch low period before the next frame.
- Undefined: the LATCH state and its counter are absent; the last accept goes straight to DONE.

Decomposition:
- Shared package/header (globals.vh):
  - state encodings (IMG_RD_ST_*)
  - BUF_BASE_ADDR and BUF_STRIDE defaults
  - PIXEL_WIDTH=24
  - FRAME_TIME, which sets the display_image pulse rate for the same LED strip
- No sub-module is needed. The address generator is a single expression, and the latch counter is a counter inside the same block.

Test Plan:
- Reset, then display_image with id=2 and PIXELS_PER_FRAME=4, memory word = 0xAA000000|addr, ack and ready always high -> addresses 0x10800, 0x10804, 0x10808, 0x1080C in order; pix_data = low 24 bits of each word; done pulses once, 10 cycles after start.
- Ack delayed 3 cycles and pix_ready low for 5 cycles on pixel 1 -> strobe and address stable until ack; pix_data stable while stalled; no pixel lost or duplicated; done after all 4 pixels.
- Second display_image while busy -> no restart, id not re-latched; after done, a new pulse with id=0 reads from 0x10000.
- Reset asserted while in READ at index 2 -> cycle/strobe/pix_valid low on the next edge; no done pulse; a following start reads index 0 first.
- id=0xFFFF_FFFF with BUF_STRIDE=1024 -> address wraps modulo 2^32 (0x0000FC00 for index 0); no X on outputs.
- IMG_READER_LATCH_GAP_EN defined with LATCH_CYCLES=10 -> done comes 10 cycles after the last accept; busy stays high; no bus activity during the gap.
